// File: rtl/trace_pkg.sv
// Shared constants and helpers for the commit trace FIFO and its word serializer.
package trace_pkg;

    // Default readout word width and the header layout derived from it.
    localparam int unsigned SLICE_W_DEF = 32;
    localparam int unsigned SEQ_W_DEF   = 16;
    localparam int unsigned DATA_W_DEF  = 1664;

    // Bit offsets of the fields inside the 1664-bit ILA record packing.
    localparam int unsigned REC_INSTRCNT_LSB = 0;     // 64 bits
    localparam int unsigned REC_WBUINSTR_LSB = 64;    // 32 bits
    localparam int unsigned REC_PC_LSB       = 96;    // 64 bits
    localparam int unsigned REC_INSTR_LSB    = 160;   // 32 bits
    localparam int unsigned REC_REGFILE_LSB  = 192;   // 32 x 32 bits
    localparam int unsigned REC_MCAUSE_LSB   = 1216;  // 64 bits
    localparam int unsigned REC_MEPC_LSB     = 1280;  // 64 bits
    localparam int unsigned REC_MTVAL_LSB    = 1344;  // 64 bits
    localparam int unsigned REC_MTVEC_LSB    = 1408;  // 64 bits
    localparam int unsigned REC_MIE_LSB      = 1472;  // 64 bits
    localparam int unsigned REC_MIP_LSB      = 1536;  // 64 bits
    localparam int unsigned REC_MSTATUS_LSB  = 1600;  // 64 bits

    // Header word: lost flag in the top bit, sequence stamp in the low bits.
    function automatic int unsigned lost_bit(input int unsigned slice_w);
        return slice_w - 1;
    endfunction

    // Words per record: one header word plus the payload rounded up to whole slices.
    function automatic int unsigned calc_nwords(input int unsigned data_w, input int unsigned slice_w);
        return ((data_w + slice_w - 1) / slice_w) + 1;
    endfunction

endpackage

// File: rtl/trace_word_serializer.sv
// Walks the head FIFO entry word by word: header first, then LSB-first payload slices.
module trace_word_serializer
    import trace_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned SLICE_W = SLICE_W_DEF,
    parameter int unsigned SEQ_W   = SEQ_W_DEF,
    localparam int unsigned NWORDS = calc_nwords(DATA_W, SLICE_W),
    localparam int unsigned IDX_W  = $clog2(NWORDS)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               head_valid_i,
    input  logic               head_lost_i,
    input  logic [SEQ_W-1:0]   head_seq_i,
    input  logic [DATA_W-1:0]  head_data_i,
    input  logic               next_i,
    output logic [SLICE_W-1:0] word_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               pop_o
);

    localparam int unsigned NDATA    = NWORDS - 1;
    localparam int unsigned PAD_W    = NDATA * SLICE_W;
    localparam int unsigned LOST_POS = lost_bit(SLICE_W);

    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic [PAD_W-1:0]   pad_s;
    logic [SLICE_W-1:0] slices_s [NDATA];
    logic [SLICE_W-1:0] word_s;
    logic               advance_s;
    logic               last_s;

    // Zero-pad the payload so the final slice is clean above DATA_W.
    assign pad_s = PAD_W'(head_data_i);

    for (genvar k = 0; k < NDATA; k++) begin : g_slice
        assign slices_s[k] = pad_s[k*SLICE_W +: SLICE_W];
    end

    assign advance_s = next_i && head_valid_i;
    assign last_s    = (idx_q == IDX_W'(NWORDS - 1));
    assign pop_o     = advance_s && last_s;

    // Next word index: flush clears, consumption advances and wraps after the last word.
    always_comb begin
        idx_d = idx_q;
        if (flush_i) begin
            idx_d = '0;
        end else if (advance_s) begin
            if (last_s) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Word index register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    // Header/slice mux; an empty FIFO reads as zero so uninitialised storage never leaks out.
    always_comb begin
        word_s = '0;
        if (!head_valid_i) begin
            word_s = '0;
        end else if (idx_q == '0) begin
            word_s[LOST_POS]    = head_lost_i;
            word_s[SEQ_W-1:0]   = head_seq_i;
        end else begin
            word_s = slices_s[idx_q - IDX_W'(1)];
        end
    end

    assign word_o = word_s;
    assign idx_o  = idx_q;

endmodule

// File: rtl/commit_trace_fifo.sv
// DEPTH-entry FIFO of commit trace records with sequence stamping, drop/stall overflow
// handling and word-serial readout of the head record.
module commit_trace_fifo
    import trace_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned SLICE_W    = SLICE_W_DEF,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned SEQ_W      = SEQ_W_DEF,
    parameter int unsigned STALL_MODE = 0,
    localparam int unsigned NWORDS    = calc_nwords(DATA_W, SLICE_W),
    localparam int unsigned IDX_W     = $clog2(NWORDS),
    localparam int unsigned AW        = $clog2(DEPTH),
    localparam int unsigned LVL_W     = AW + 1
) (
    input  logic               s_axi_aclk,
    input  logic               s_axi_aresetn,
    input  logic               en,
    input  logic               rec_valid,
    input  logic [DATA_W-1:0]  rec_data,
    output logic               rec_ready,
    output logic [SLICE_W-1:0] rd_word,
    output logic               rd_word_valid,
    output logic [IDX_W-1:0]   rd_word_idx,
    input  logic               rd_word_next,
    output logic               axi_read_en,
    output logic [LVL_W-1:0]   level,
    output logic [31:0]        drop_cnt,
    output logic               overflow
);

    localparam int unsigned ENTRY_W = 1 + SEQ_W + DATA_W;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic               lost_pend_q, lost_pend_d;
    logic [31:0]        drop_cnt_q, drop_cnt_d;
    logic               overflow_q, overflow_d;
    logic               axi_read_en_q, axi_read_en_d;

    logic [LVL_W-1:0]   level_s;
    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               drop_s;
    logic               pop_s;
    logic               ser_pop_s;
    logic [ENTRY_W-1:0] head_s;

    assign level_s = wr_ptr_q - rd_ptr_q;
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_s  = en && rec_valid && !full_s;
    assign drop_s  = en && rec_valid && full_s && (STALL_MODE == 0);
    assign pop_s   = en && ser_pop_s;
    assign head_s  = mem_q[rd_ptr_q[AW-1:0]];

    // Next-state for pointers, stamping, overflow bookkeeping and the head-available pulse.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        seq_d         = seq_q;
        lost_pend_d   = lost_pend_q;
        drop_cnt_d    = drop_cnt_q;
        overflow_d    = overflow_q;
        axi_read_en_d = 1'b0;
        if (!en) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            seq_d       = '0;
            lost_pend_d = 1'b0;
            drop_cnt_d  = 32'd0;
            overflow_d  = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_d    = wr_ptr_q + (AW+1)'(1);
                seq_d       = seq_q + SEQ_W'(1);
                lost_pend_d = 1'b0;
            end else if (drop_s) begin
                lost_pend_d = 1'b1;
                overflow_d  = 1'b1;
                if (drop_cnt_q != 32'hFFFF_FFFF) begin
                    drop_cnt_d = drop_cnt_q + 32'd1;
                end else begin
                    drop_cnt_d = drop_cnt_q;
                end
            end else begin
                lost_pend_d = lost_pend_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            // A pop in the same cycle as a push at level 1 still leaves a fresh head behind.
            axi_read_en_d = (push_s && empty_s) ||
                            (pop_s && ((level_s > LVL_W'(1)) || push_s));
        end
    end

    // Control state registers.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            seq_q         <= '0;
            lost_pend_q   <= 1'b0;
            drop_cnt_q    <= 32'd0;
            overflow_q    <= 1'b0;
            axi_read_en_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            seq_q         <= seq_d;
            lost_pend_q   <= lost_pend_d;
            drop_cnt_q    <= drop_cnt_d;
            overflow_q    <= overflow_d;
            axi_read_en_q <= axi_read_en_d;
        end
    end

    // Record storage; contents need no reset because the pointers gate visibility.
    always_ff @(posedge s_axi_aclk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {lost_pend_q, seq_q, rec_data};
        end
    end

    trace_word_serializer #(
        .DATA_W  (DATA_W),
        .SLICE_W (SLICE_W),
        .SEQ_W   (SEQ_W)
    ) u_serializer (
        .clk_i        (s_axi_aclk),
        .rst_ni       (s_axi_aresetn),
        .flush_i      (!en),
        .head_valid_i (!empty_s),
        .head_lost_i  (head_s[ENTRY_W-1]),
        .head_seq_i   (head_s[DATA_W +: SEQ_W]),
        .head_data_i  (head_s[DATA_W-1:0]),
        .next_i       (rd_word_next),
        .word_o       (rd_word),
        .idx_o        (rd_word_idx),
        .pop_o        (ser_pop_s)
    );

    assign rec_ready     = !full_s;
    assign rd_word_valid = !empty_s;
    assign level         = level_s;
    assign axi_read_en   = axi_read_en_q;
    assign drop_cnt      = drop_cnt_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Bench: a drop-mode and a stall-mode instance run side by side against a list-based
// model of the FIFO; directed scenarios add literal expectations.
module tb_commit_trace_fifo;

    localparam int DATA_W = 1664;
    localparam int NDATA  = 52;
    localparam int NW     = 53;
    localparam int DEPTH  = 4;
    localparam int EW     = 1 + 16 + DATA_W;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              en_i  [2];
    logic              vld_i [2];
    logic [DATA_W-1:0] dat_i [2];
    logic              nxt_i [2];
    logic              o_ready [2];
    logic              o_wvalid[2];
    logic              o_axi   [2];
    logic              o_ovf   [2];
    logic [31:0]       o_word  [2];
    logic [31:0]       o_drop  [2];
    logic [5:0]        o_idx   [2];
    logic [2:0]        o_lvl   [2];

    commit_trace_fifo #(.STALL_MODE(0)) u_drop (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .en(en_i[0]), .rec_valid(vld_i[0]),
        .rec_data(dat_i[0]), .rec_ready(o_ready[0]), .rd_word(o_word[0]),
        .rd_word_valid(o_wvalid[0]), .rd_word_idx(o_idx[0]), .rd_word_next(nxt_i[0]),
        .axi_read_en(o_axi[0]), .level(o_lvl[0]), .drop_cnt(o_drop[0]), .overflow(o_ovf[0]));

    commit_trace_fifo #(.STALL_MODE(1)) u_stall (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .en(en_i[1]), .rec_valid(vld_i[1]),
        .rec_data(dat_i[1]), .rec_ready(o_ready[1]), .rd_word(o_word[1]),
        .rd_word_valid(o_wvalid[1]), .rd_word_idx(o_idx[1]), .rd_word_next(nxt_i[1]),
        .axi_read_en(o_axi[1]), .level(o_lvl[1]), .drop_cnt(o_drop[1]), .overflow(o_ovf[1]));

    // Model: each instance is a list of {lost, seq, data} records, head at position 0.
    logic [EW-1:0] mq [2][8];
    int     mcnt[2], midx[2], mseq[2];
    bit     mpend[2], movf[2], maxi[2], macc[2];
    longint mdrop[2];

    int total = 0, passed = 0, fails = 0;
    logic [31:0] hdr0[$], hdr1[$];
    bit cap_on = 0;
    bit prev0[2];

    task automatic chk(input string nm, input int m, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else begin
            fails++;
            if (fails <= 50) $display("FAIL %s[%0d] @%0t: got %0h expected %0h", nm, m, $time, act, exp);
        end
    endtask

    task automatic model_clear(input int m);
        mcnt[m] = 0; midx[m] = 0; mseq[m] = 0; mpend[m] = 0;
        mdrop[m] = 0; movf[m] = 0; maxi[m] = 0; macc[m] = 0;
    endtask

    // Apply one clock edge worth of the behavioural rules using the inputs held across it.
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            bit full, empty, push, drop, pop;
            macc[m] = 0;
            if (!en_i[m]) model_clear(m);
            else begin
                full  = (mcnt[m] == DEPTH);
                empty = (mcnt[m] == 0);
                push  = vld_i[m] && !full;
                drop  = vld_i[m] && full && (m == 0);
                pop   = nxt_i[m] && !empty && (midx[m] == NW - 1);
                maxi[m] = (push && empty) || (pop && (mcnt[m] > 1 || push));
                if (nxt_i[m] && !empty) midx[m] = (midx[m] == NW - 1) ? 0 : midx[m] + 1;
                if (pop) begin
                    for (int i = 0; i < 7; i++) mq[m][i] = mq[m][i+1];
                    mcnt[m]--;
                end
                if (push) begin
                    mq[m][mcnt[m]] = {mpend[m], 16'(mseq[m]), dat_i[m]};
                    mcnt[m]++;
                    mseq[m] = (mseq[m] + 1) % 65536;
                    mpend[m] = 0;
                    macc[m] = 1;
                end
                if (drop) begin
                    if (mdrop[m] < 64'hFFFF_FFFF) mdrop[m]++;
                    movf[m] = 1;
                    mpend[m] = 1;
                end
            end
        end
    endtask

    function automatic logic [31:0] exp_word(input int m);
        logic [EW-1:0] h;
        logic [31:0] w;
        w = 32'h0;
        if (mcnt[m] == 0) return w;
        h = mq[m][0];
        if (midx[m] == 0) begin
            w[31]   = h[EW-1];
            w[15:0] = h[EW-2 -: 16];
        end else begin
            for (int b = 0; b < 32; b++) begin
                int p = (midx[m] - 1) * 32 + b;
                if (p < DATA_W) w[b] = h[11'(p)];
            end
        end
        return w;
    endfunction

    task automatic compare_all();
        for (int m = 0; m < 2; m++) begin
            chk("rec_ready",     m, 64'(o_ready[m]),  64'(mcnt[m] != DEPTH));
            chk("rd_word_valid", m, 64'(o_wvalid[m]), 64'(mcnt[m] != 0));
            chk("rd_word_idx",   m, 64'(o_idx[m]),    64'(midx[m]));
            chk("rd_word",       m, 64'(o_word[m]),   64'(exp_word(m)));
            chk("axi_read_en",   m, 64'(o_axi[m]),    64'(maxi[m]));
            chk("level",         m, 64'(o_lvl[m]),    64'(mcnt[m]));
            chk("drop_cnt",      m, 64'(o_drop[m]),   64'(mdrop[m]));
            chk("overflow",      m, 64'(o_ovf[m]),    64'(movf[m]));
        end
    endtask

    task automatic cap();
        for (int m = 0; m < 2; m++) begin
            bit cur;
            cur = o_wvalid[m] && (o_idx[m] == 6'd0);
            if (cur && !prev0[m]) begin
                if (m == 0) hdr0.push_back(o_word[m]);
                else        hdr1.push_back(o_word[m]);
            end
            prev0[m] = cur;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        if (cap_on) cap();
    endtask

    task automatic chk_rst(input string nm);
        for (int m = 0; m < 2; m++) begin
            chk({nm, "_ready"}, m, 64'(o_ready[m]),  64'd1);
            chk({nm, "_valid"}, m, 64'(o_wvalid[m]), 64'd0);
            chk({nm, "_idx"},   m, 64'(o_idx[m]),    64'd0);
            chk({nm, "_word"},  m, 64'(o_word[m]),   64'd0);
            chk({nm, "_axi"},   m, 64'(o_axi[m]),    64'd0);
            chk({nm, "_level"}, m, 64'(o_lvl[m]),    64'd0);
            chk({nm, "_drop"},  m, 64'(o_drop[m]),   64'd0);
            chk({nm, "_ovf"},   m, 64'(o_ovf[m]),    64'd0);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_rec();
        logic [DATA_W-1:0] r;
        r = '0;
        for (int j = 0; j < NDATA; j++) r = (r << 32) | DATA_W'($urandom());
        return r;
    endfunction

    task automatic set_both(input bit en, input bit vld, input bit nxt);
        for (int m = 0; m < 2; m++) begin
            en_i[m] = en; vld_i[m] = vld; nxt_i[m] = nxt;
        end
    endtask

    task automatic flush();
        set_both(1'b0, 1'b0, 1'b0);
        tick();
        set_both(1'b1, 1'b0, 1'b0);
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) begin
            vld_i[0] = 1'b1; vld_i[1] = 1'b1;
            dat_i[0] = rnd_rec(); dat_i[1] = rnd_rec();
            tick();
        end
        vld_i[0] = 1'b0; vld_i[1] = 1'b0;
    endtask

    int n1;

    // Stall-side producer: hold the record until it is taken, then offer the next one.
    task automatic stall_drive(input int limit);
        if (macc[1]) begin
            n1++;
            dat_i[1] = rnd_rec();
        end
        vld_i[1] = (n1 < limit);
    endtask

    initial begin
        logic [DATA_W-1:0] pat;
        int guard;
        rst_n = 1'b0;
        set_both(1'b1, 1'b0, 1'b0);
        dat_i[0] = '0; dat_i[1] = '0;
        model_clear(0); model_clear(1);
        #12;
        chk_rst("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: one patterned record, full readout.
        pat = '0;
        for (int j = NDATA - 1; j >= 0; j--) pat = (pat << 32) | DATA_W'(32'hA5A5_0000 + 32'(j + 1));
        dat_i[0] = pat; dat_i[1] = pat;
        vld_i[0] = 1'b1; vld_i[1] = 1'b1;
        tick();
        chk("t1_axi_pulse", 0, 64'(o_axi[0]), 64'd1);
        chk("t1_word0", 0, 64'(o_word[0]), 64'h0);
        set_both(1'b1, 1'b0, 1'b1);
        tick();
        chk("t1_word1", 0, 64'(o_word[0]), 64'hA5A5_0001);
        for (int k = 2; k <= 52; k++) tick();
        chk("t1_word52", 0, 64'(o_word[0]), 64'hA5A5_0034);
        tick();
        chk("t1_valid_end", 0, 64'(o_wvalid[0]), 64'd0);
        chk("t1_level_end", 0, 64'(o_lvl[0]), 64'd0);

        // 2/3: six back-to-back records, drop vs stall.
        flush();
        n1 = 0;
        vld_i[0] = 1'b1; vld_i[1] = 1'b1;
        dat_i[0] = rnd_rec(); dat_i[1] = rnd_rec();
        for (int i = 0; i < 6; i++) begin
            tick();
            dat_i[0] = rnd_rec();
            stall_drive(6);
        end
        vld_i[0] = 1'b0;
        chk("t2_level", 0, 64'(o_lvl[0]), 64'd4);
        chk("t2_drop", 0, 64'(o_drop[0]), 64'd2);
        chk("t2_ovf", 0, 64'(o_ovf[0]), 64'd1);
        chk("t3_ready_full", 1, 64'(o_ready[1]), 64'd0);
        chk("t3_drop", 1, 64'(o_drop[1]), 64'd0);
        cap_on = 1; prev0[0] = 0; prev0[1] = 0;
        cap();
        nxt_i[0] = 1'b1; nxt_i[1] = 1'b1;
        for (int i = 0; i < NW; i++) begin tick(); stall_drive(6); end
        nxt_i[0] = 1'b0; vld_i[0] = 1'b1; dat_i[0] = rnd_rec();
        tick(); stall_drive(6);
        vld_i[0] = 1'b0; nxt_i[0] = 1'b1;
        guard = 0;
        while ((o_wvalid[0] || o_wvalid[1] || vld_i[1]) && guard < 600) begin
            tick(); stall_drive(6); guard++;
        end
        chk("drain_in_time", 0, 64'(guard < 600), 64'd1);
        cap_on = 0;
        chk("t2_hdr_count", 0, 64'(hdr0.size()), 64'd5);
        chk("t3_hdr_count", 1, 64'(hdr1.size()), 64'd6);
        if (hdr0.size() == 5) begin
            chk("t2_hdr0", 0, 64'(hdr0[0]), 64'h0);
            chk("t2_hdr1", 0, 64'(hdr0[1]), 64'h1);
            chk("t2_hdr3", 0, 64'(hdr0[3]), 64'h3);
            chk("t2_hdr_lost", 0, 64'(hdr0[4]), 64'h8000_0004);
        end
        if (hdr1.size() == 6) begin
            for (int i = 0; i < 6; i++) chk("t3_hdr", 1, 64'(hdr1[i]), 64'(i));
        end
        nxt_i[0] = 1'b0; nxt_i[1] = 1'b0; vld_i[1] = 1'b0;

        // 4: level 2, push together with the final-word pop.
        flush();
        push_n(2);
        nxt_i[0] = 1'b1; nxt_i[1] = 1'b1;
        for (int i = 0; i < NW - 1; i++) tick();
        vld_i[0] = 1'b1; vld_i[1] = 1'b1;
        dat_i[0] = rnd_rec(); dat_i[1] = rnd_rec();
        tick();
        for (int m = 0; m < 2; m++) begin
            chk("t4_level", m, 64'(o_lvl[m]), 64'd2);
            chk("t4_axi", m, 64'(o_axi[m]), 64'd1);
            chk("t4_head_seq", m, 64'(o_word[m]), 64'h1);
        end
        set_both(1'b1, 1'b0, 1'b0);

        // 5: full, incoming record in the same cycle as the final-word pop.
        flush();
        push_n(4);
        nxt_i[0] = 1'b1; nxt_i[1] = 1'b1;
        for (int i = 0; i < NW - 1; i++) tick();
        vld_i[0] = 1'b1; vld_i[1] = 1'b1;
        tick();
        chk("t5_level", 0, 64'(o_lvl[0]), 64'd3);
        chk("t5_drop", 0, 64'(o_drop[0]), 64'd1);
        chk("t5_stall_level", 1, 64'(o_lvl[1]), 64'd3);
        chk("t5_stall_drop", 1, 64'(o_drop[1]), 64'd0);
        set_both(1'b1, 1'b0, 1'b0);

        // 6: flush and async reset in the middle of a record.
        flush();
        push_n(3);
        nxt_i[0] = 1'b1; nxt_i[1] = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("t6_idx20", 0, 64'(o_idx[0]), 64'd20);
        set_both(1'b0, 1'b0, 1'b0);
        tick();
        chk("t6_flush_level", 0, 64'(o_lvl[0]), 64'd0);
        chk("t6_flush_valid", 0, 64'(o_wvalid[0]), 64'd0);
        set_both(1'b1, 1'b0, 1'b0);
        push_n(2);
        nxt_i[0] = 1'b1; nxt_i[1] = 1'b1;
        for (int i = 0; i < NW; i++) tick();
        chk("t6_seq_restart", 0, 64'(o_word[0]), 64'h1);
        nxt_i[0] = 1'b0; nxt_i[1] = 1'b0;
        push_n(1);
        nxt_i[0] = 1'b1; nxt_i[1] = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        #2 rst_n = 1'b0;
        #1 chk_rst("async");
        model_clear(0); model_clear(1);
        set_both(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic on both instances.
        n1 = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < 2; m++) begin
                en_i[m]  = ($urandom_range(0, 149) != 0);
                nxt_i[m] = ($urandom_range(0, 9) < 8);
            end
            vld_i[0] = ($urandom_range(0, 9) < 4);
            dat_i[0] = rnd_rec();
            if (!vld_i[1] || macc[1] || !en_i[1]) begin
                vld_i[1] = ($urandom_range(0, 9) < 4);
                dat_i[1] = rnd_rec();
            end
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/commit_trace_fifo.md
Name: commit_trace_fifo

Overview:
- Parametrised successor to the single-entry commit snapshot latch. Captures per-commit trace records (PC, instruction, CSR snapshot, counters) into a DEPTH-entry FIFO.
- Serialises the head record as SLICE_W-bit words for AXI-Lite register readout, so the host does not lose commits while it reads.
- Supports drop or stall overflow mode, per-record sequence stamping and a lost-record flag. Sits between the core's commit/ILA taps and the AXI slave register file.

Parameters:
DATA_W, 1664, trace record payload width.
SLICE_W, 32, readout word width; DATA_W need not be a multiple.
DEPTH, 4, FIFO entries; power of two, >=2.
SEQ_W, 16, sequence stamp width; must be <= SLICE_W-1.
STALL_MODE, 0, 0 = drop records when full, 1 = back-pressure producer via rec_ready.

Ports:
s_axi_aclk  in  1  clock.
s_axi_aresetn  in  1  asynchronous active-low reset.
en  in  1  capture enable; low = synchronous flush.
rec_valid  in  1  commit record present this cycle.
rec_data  in  DATA_W  packed trace record.
rec_ready  out  1  FIFO can accept (= !full).
rd_word  out  SLICE_W  current readout word of head record.
rd_word_valid  out  1  FIFO non-empty.
rd_word_idx  out  $clog2(NWORDS)  index of rd_word within record.
rd_word_next  in  1  pulse: host consumed rd_word.
axi_read_en  out  1  one-cycle pulse: new head record available.
level  out  $clog2(DEPTH)+1  occupied entries.
drop_cnt  out  32  saturating count of dropped records.
overflow  out  1  sticky: at least one drop since reset/flush.

Behaviour:
- Derived: NDATA = ceil(DATA_W/SLICE_W); NWORDS = NDATA+1 (word 0 is the header).
- Reset (async) or en low (sync, next edge): pointers, level, word index, seq, drop_cnt, overflow, and the pending-lost flag go to 0. All outputs are 0 except rec_ready = 1. Storage contents need no reset.
- Push when rec_valid && rec_ready && en.
  - Stored entry = {lost_flag, seq, rec_data}.
  - seq increments mod 2^SEQ_W on every accepted record, starting at 0.
- Drop when rec_valid && !rec_ready && en, in drop mode only.
  - drop_cnt increments, saturating at 0xFFFFFFFF.
  - overflow set; pending-lost flag set.
  - The next accepted record stores lost_flag = 1, which clears the pending-lost flag.
- Stall mode: the producer holds rec_valid/rec_data until rec_ready. drop_cnt stays 0.
- rec_ready = !full, taken from registered state. A pop in the same cycle does not free a slot for a simultaneous push, so a push at full in that cycle is dropped or stalled.
- Readout word contents (head record):
  - Word 0 = {lost_flag, zeros, seq}.
  - Word k (1..NDATA) = rec_data[(k-1)*SLICE_W +: SLICE_W], LSB-first.
  - The last word is zero-padded above DATA_W.
  - rd_word is a combinational mux of head storage by word index.
- rd_word_next while rd_word_valid:
  - Word index increments.
  - At index NWORDS-1, the record is popped and the index returns to 0.
- rd_word_next while empty is ignored.
- Latency: a record pushed at edge N gives rd_word_valid = 1 after edge N.
- axi_read_en pulses in the cycle after either:
  - a push into an empty FIFO, or
  - a pop that leaves the FIFO non-empty.
- Simultaneous push and pop (not full): level unchanged, both take effect.
- Pointers are DEPTH-wrap binary with an extra MSB: full when MSBs differ and the rest match.
- Asserting reset mid-record discards the partial readout.

Decomposition:
- Shared package trace_pkg holds:
  - SLICE_W default and header bit positions (LOST_BIT = SLICE_W-1, SEQ field [SEQ_W-1:0]).
  - NWORDS computation function.
  - The record field-offset constants for the 1664-bit ILA packing (instrcnt, WBUInstr, pc, ... mstatus).
- One natural sub-module: trace_word_serializer. It holds the word-index counter, the header/slice mux and pop generation, and is fed the head entry.

Test Plan:
1. Defaults, one record with rec_data = {52{32'hA5A5_0000 + k}}:
   - Expect axi_read_en pulse one cycle after push.
   - Word 0 = 0x0000_0000; words 1..52 match slices.
   - After 53 rd_word_next pulses: rd_word_valid = 0, level = 0.
2. Drop mode, DEPTH = 4, push 6 back-to-back, no reads:
   - level = 4, drop_cnt = 2, overflow = 1.
   - Push a 7th after popping one record: its header = 0x8000_0004 (lost = 1, seq = 4).
3. STALL_MODE = 1, push 6 with rec_valid held:
   - rec_ready = 0 when level = 4; drop_cnt = 0.
   - Drain all records: seq sequence 0..5, all lost = 0.
4. Level 2, push and final-word rd_word_next in the same cycle:
   - level stays 2; axi_read_en pulses; new head seq = 1.
5. Level 4 (full), rec_valid and final rd_word_next in the same cycle, drop mode:
   - Record dropped, drop_cnt = 1, level = 3.
6. Mid-readout, at word 20 of seq 0 with level 3:
   - en low for one cycle: level = 0, rd_word_valid = 0, seq restarts at 0.
   - Repeat with s_axi_aresetn low asynchronously: outputs clear without waiting for a clock edge.
